// File: rtl/fetch_sequencer_pkg.sv
// Shared widths, reset PC and state encoding for the instruction-fetch sequencer.
// Latency: n/a (type/constant definitions only); backpressure: n/a.
package fetch_sequencer_pkg;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_INST_W   = 32;
    localparam int DEF_RESET_PC = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bundle: control inputs, memory address/data and the decode output slot.
// Latency: wires only; backpressure: inst_valid/inst_ready on the slot.
interface fetch_sequencer_if
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INST_W = DEF_INST_W
);
    logic              start;
    logic              halt;
    logic              branch_valid;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_inst;
    logic [INST_W-1:0] inst_out;
    logic [ADDR_W-1:0] pc_out;
    logic              inst_valid;
    logic              inst_ready;
    logic              running;

    modport master (
        input  start, halt, branch_valid, branch_target, mem_inst, inst_ready,
        output mem_addr, inst_out, pc_out, inst_valid, running
    );

    modport slave (
        output start, halt, branch_valid, branch_target, mem_inst, inst_ready,
        input  mem_addr, inst_out, pc_out, inst_valid, running
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch PC sequencer over a registered-read memory; start->first word 3 edges, 1 word/cycle.
// Backpressure: a held slot freezes PC/in-flight state and replays the in-flight address.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int INST_W   = DEF_INST_W,
    parameter int RESET_PC = DEF_RESET_PC
)(
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic [INST_W-1:0] slot_inst;
    logic [ADDR_W-1:0] slot_pc;
    logic              slot_vld;

    logic hold;
    logic issue;

    assign hold  = slot_vld & ~bus.inst_ready;
    assign issue = (state == RUN) & ~bus.halt & ~bus.branch_valid & ~hold;

    // Re-present the in-flight address while stalled so mem_inst stays valid for it.
    assign bus.mem_addr   = (hold & inflight) ? inflight_pc : fetch_pc;
    assign bus.inst_out   = slot_inst;
    assign bus.pc_out     = slot_pc;
    assign bus.inst_valid = slot_vld;
    assign bus.running    = (state == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            fetch_pc    <= ADDR_W'(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
            slot_inst   <= '0;
            slot_pc     <= '0;
            slot_vld    <= 1'b0;
        end else begin
            // A redirect only reloads the PC; it never moves the state machine.
            if (!bus.branch_valid) begin
                case (state)
                    IDLE, HALTED: if (bus.start && !bus.halt) state <= RUN;
                    RUN:          if (bus.halt) state <= HALTED;
                    default:      state <= IDLE;
                endcase
            end

            if (bus.branch_valid) begin
                fetch_pc <= bus.branch_target;
                inflight <= 1'b0;
                slot_vld <= 1'b0;
            end else if (!hold) begin
                slot_inst <= bus.mem_inst;
                slot_pc   <= inflight_pc;
                slot_vld  <= inflight;
                inflight  <= issue;
                if (issue) begin
                    inflight_pc <= fetch_pc;
                    fetch_pc    <= fetch_pc + ADDR_W'(1);
                end
            end
        end
    end

endmodule
